sram_req_bridge: RTL and testbench

- Initiator end of sram_if. Converts a valid/ready request channel into single-cycle SRAM accesses on an sram_if master modport.
- Captures the synchronous 1-cycle read data into a small response FIFO, returned on a valid/ready response channel.
- Sits between a core/LSU-side requester and the sram model or macro. It lets upstream apply backpressure without losing read data.

---
 rtl/sram_if.sv | 25 ++
 rtl/sram_req_bridge.sv | 106 ++++++++++
 tb/tb_sram_req_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_if.sv
// Single-port synchronous SRAM access bundle.
// Writes take effect at the edge; read data follows one cycle later.
interface sram_if #(
   parameter int AW = 15,
   parameter int DW = 32
);
   logic [AW-1:0] addr;
   logic          wen;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (
      output addr,
      output wen,
      output wdata,
      input  rdata
   );

   modport slave (
      input  addr,
      input  wen,
      input  wdata,
      output rdata
   );
endinterface

// File: rtl/sram_req_bridge.sv
// Valid/ready request channel to single-cycle SRAM accesses.
// Read data lands in a small response FIFO guarded by read credits.
module sram_req_bridge #(
   parameter int AW        = 15,
   parameter int DW        = 32,
   parameter int RSP_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic          req_wen,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_rdata,
   sram_if.master        sram_rw
);

   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [DW-1:0] fifo_q [RSP_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          rd_inflight;

   logic          push;
   logic          pop;
   logic          rd_acc;
   logic          credit_ok;
   logic [CW:0]   occ;

   assign push = rd_inflight;
   assign pop  = rsp_vld & rsp_rdy;

   // Occupancy counts the in-flight read, net of this cycle's pop.
   assign occ = {1'b0, fifo_cnt}
              + {{CW{1'b0}}, rd_inflight}
              - {{CW{1'b0}}, pop};

   assign credit_ok = occ < (CW+1)'(RSP_DEPTH);
   assign req_rdy   = rst_n & (req_wen | credit_ok);
   assign rd_acc    = req_vld & req_rdy & ~req_wen;

   assign sram_rw.addr  = req_addr;
   assign sram_rw.wdata = req_wdata;
   assign sram_rw.wen   = req_vld & req_rdy & req_wen;

   assign rsp_vld   = fifo_cnt != '0;
   assign rsp_rdata = rsp_vld ? fifo_q[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_inflight <= 1'b0;
      end else begin
         rd_inflight <= rd_acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (push) begin
         if (wr_ptr == PW'(RSP_DEPTH - 1)) begin
            wr_ptr <= '0;
         end else begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (pop) begin
         if (rd_ptr == PW'(RSP_DEPTH - 1)) begin
            rd_ptr <= '0;
         end else begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_cnt <= '0;
      end else begin
         unique case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Payload storage needs no reset; fifo_cnt qualifies every entry.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr] <= sram_rw.rdata;
      end
   end

endmodule

// File: tb/tb_sram_req_bridge.sv
// Scoreboard bench for sram_req_bridge with a behavioural SRAM.
// Directed scenarios followed by randomized mixed traffic.
module tb_sram_req_bridge;

   localparam int AW    = 15;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wen;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_rdata;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   bit            lat_chk = 1'b0;
   exp_t          expq[$];
   logic [DW-1:0] ref_mem [64];
   logic [DW-1:0] sram_mem [64];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sram_if #(.AW(AW), .DW(DW)) sif ();

   sram_req_bridge #(
      .AW(AW),
      .DW(DW),
      .RSP_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_vld(req_vld),
      .req_rdy(req_rdy),
      .req_wen(req_wen),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_vld(rsp_vld),
      .rsp_rdy(rsp_rdy),
      .rsp_rdata(rsp_rdata),
      .sram_rw(sif)
   );

   // Synchronous SRAM: write at the edge, old data read back next cycle.
   always @(posedge clk) begin
      if (sif.wen) sram_mem[sif.addr[5:0]] <= sif.wdata;
      sif.rdata <= sram_mem[sif.addr[5:0]];
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon_loop();
      logic          pv;
      logic [DW-1:0] pd;
      exp_t          e;
      pv = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expq.delete();
            pv = 1'b0;
            continue;
         end
         chk("fifo_cnt_bound", 64'(dut.fifo_cnt <= DEPTH), 64'd1);
         if (pv) begin
            chk("rsp_hold_vld", 64'(rsp_vld), 64'd1);
            chk("rsp_hold_data", 64'(rsp_rdata), 64'(pd));
         end
         if (req_vld && req_rdy) begin
            if (req_wen) begin
               ref_mem[req_addr[5:0]] = req_wdata;
            end else begin
               e.d = ref_mem[req_addr[5:0]];
               e.c = cyc;
               expq.push_back(e);
            end
         end
         if (rsp_vld && rsp_rdy) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got data %0h expected none",
                        rsp_rdata);
            end else begin
               e = expq.pop_front();
               chk("rsp_data", 64'(rsp_rdata), 64'(e.d));
               if (lat_chk) chk("rsp_latency", 64'(cyc - e.c), 64'd2);
            end
         end
         pv = rsp_vld && !rsp_rdy;
         pd = rsp_rdata;
      end
   endtask

   // Caller sits 1 time unit after a posedge; returns at the same phase.
   task automatic req(input bit w, input logic [5:0] a,
                      input logic [DW-1:0] d, input bit rnd,
                      output int waits);
      req_vld   = 1'b1;
      req_wen   = w;
      req_addr  = {{(AW-6){1'b0}}, a};
      req_wdata = d;
      waits     = 0;
      forever begin
         @(negedge clk);
         if (req_rdy) break;
         waits++;
         if (waits > 200) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got %0d stall cycles expected <=200",
                     waits);
            break;
         end
         @(posedge clk);
         #1;
         if (rnd) rsp_rdy = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      req_vld = 1'b0;
      if (rnd) rsp_rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int            w;
      int            w3;
      int            n;
      logic [DW-1:0] v;

      req_vld   = 1'b1;
      req_wen   = 1'b1;
      req_addr  = AW'('h10);
      req_wdata = '1;
      rsp_rdy   = 1'b0;
      fork
         mon_loop();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_sram_wen", 64'(sif.wen), 64'd0);
      chk("rst_req_rdy", 64'(req_rdy), 64'd0);
      chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_fifo_cnt", 64'(dut.fifo_cnt), 64'd0);
      @(posedge clk);
      #1;
      req_vld = 1'b0;
      rst_n   = 1'b1;
      idle(1);

      for (int i = 0; i < 64; i++) begin
         v = (i < 8) ? DW'(i * 3) : DW'($urandom);
         req(1'b1, 6'(i), v, 1'b0, w);
         chk("preload_wr_waits", 64'(w), 64'd0);
      end

      rsp_rdy = 1'b1;
      lat_chk = 1'b1;
      req(1'b1, 6'h10, 32'hDEADBEEF, 1'b0, w);
      req(1'b0, 6'h10, '0, 1'b0, w);
      idle(4);
      chk("wr_rd_drained", 64'(expq.size()), 64'd0);

      for (int i = 0; i < 8; i++) begin
         req(1'b0, 6'(i), '0, 1'b0, w);
         chk("stream_no_bubble", 64'(w), 64'd0);
      end
      idle(4);
      lat_chk = 1'b0;
      chk("stream_drained", 64'(expq.size()), 64'd0);

      rsp_rdy = 1'b0;
      req(1'b0, 6'd1, '0, 1'b0, w);
      chk("bp_rd0_waits", 64'(w), 64'd0);
      req(1'b0, 6'd2, '0, 1'b0, w);
      chk("bp_rd1_waits", 64'(w), 64'd0);
      fork
         req(1'b0, 6'd3, '0, 1'b0, w3);
         begin
            repeat (4) begin
               @(negedge clk);
               chk("bp_req_rdy_low", 64'(req_rdy), 64'd0);
            end
            chk("bp_fifo_full", 64'(dut.fifo_cnt), 64'd2);
            @(posedge clk);
            #1;
            rsp_rdy = 1'b1;
         end
      join
      chk("bp_rd2_stalled", 64'(w3 >= 4), 64'd1);
      req(1'b0, 6'd4, '0, 1'b0, w);
      idle(5);
      chk("bp_drained", 64'(expq.size()), 64'd0);

      rsp_rdy = 1'b0;
      req(1'b0, 6'd5, '0, 1'b0, w);
      req(1'b0, 6'd6, '0, 1'b0, w);
      idle(2);
      chk("full_fifo_cnt", 64'(dut.fifo_cnt), 64'd2);
      req(1'b1, 6'h20, 32'hCAFE0020, 1'b0, w);
      chk("full_write_waits", 64'(w), 64'd0);
      rsp_rdy = 1'b1;
      idle(3);
      req(1'b0, 6'h20, '0, 1'b0, w);
      idle(4);
      chk("full_drained", 64'(expq.size()), 64'd0);

      req(1'b0, 6'd7, '0, 1'b0, w);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", 64'(rsp_vld), 64'd0);
         chk("rst_mid_cnt", 64'(dut.fifo_cnt), 64'd0);
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
               rsp_rdy = 1'($urandom_range(0, 1));
            end
         end else begin
            req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                DW'($urandom), 1'b1, w);
         end
      end

      rsp_rdy = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("final_drained", 64'(expq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
